slow2fast_sync_bank: RTL and testbench



---
 rtl/slow2fast_sync_bank_if.sv | 24 ++
 rtl/slow2fast_sync_bank.sv | 94 +++++++++
 tb/tb_slow2fast_sync_bank.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/slow2fast_sync_bank_if.sv
// Signal bundle for slow2fast_sync_bank: slow-domain bits and per-channel controls in,
// filtered levels, detector pulses and event counters out.
interface slow2fast_sync_bank_if #(
   parameter int CH    = 4,
   parameter int CNT_W = 8
);
   logic [CH-1:0]       data_in;
   logic [2*CH-1:0]     mode;
   logic [CH-1:0]       cnt_clr;
   logic [CH-1:0]       level_out;
   logic [CH-1:0]       pulse_out;
   logic [CH*CNT_W-1:0] evt_cnt;
   logic [CH-1:0]       cnt_ovf;

   modport master (
      output data_in, mode, cnt_clr,
      input  level_out, pulse_out, evt_cnt, cnt_ovf
   );

   modport slave (
      input  data_in, mode, cnt_clr,
      output level_out, pulse_out, evt_cnt, cnt_ovf
   );
endinterface

// File: rtl/slow2fast_sync_bank.sv
// Multi-channel slow-to-fast single-bit synchronizer bank: sync chain, stable-count
// glitch filter, mode-selectable edge detector and saturating event counter per channel.
module slow2fast_sync_bank #(
   parameter int CH       = 4,
   parameter int STAGES   = 3,
   parameter int FILT_LEN = 2,
   parameter int CNT_W    = 8
) (
   input logic                  clk_fast,
   input logic                  rst,
   slow2fast_sync_bank_if.slave bus
);
   localparam int              FC_W    = $clog2(FILT_LEN + 1);
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic [STAGES-1:0] sync;
      logic              s;
      logic              filt;
      logic              filt_d;
      logic [FC_W-1:0]   fc;
      logic              pulse;
      logic              pulse_nxt;
      logic [1:0]        ch_mode;
      logic              edge_mode;
      logic [CNT_W-1:0]  cnt;
      logic              ovf;

      assign ch_mode   = bus.mode[2*i +: 2];
      assign edge_mode = (ch_mode != 2'b00);
      assign s         = sync[STAGES-1];

      // Plain flop chain: nothing may sit between the metastability stages.
      always_ff @(posedge clk_fast or posedge rst) begin
         if (rst) sync <= '0;
         else     sync <= {sync[STAGES-2:0], bus.data_in[i]};
      end

      // filt follows s only after FILT_LEN consecutive disagreeing cycles.
      always_ff @(posedge clk_fast or posedge rst) begin
         if (rst) begin
            filt <= 1'b0;
            fc   <= '0;
         end else if (s == filt) begin
            fc <= '0;
         end else if (fc == FC_LAST) begin
            filt <= s;
            fc   <= '0;
         end else begin
            fc <= fc + FC_W'(1);
         end
      end

      always_comb begin
         pulse_nxt = 1'b0;
         case (ch_mode)
            2'b00:   pulse_nxt = filt;
            2'b01:   pulse_nxt = filt & ~filt_d;
            2'b10:   pulse_nxt = ~filt & filt_d;
            default: pulse_nxt = filt ^ filt_d;
         endcase
      end

      always_ff @(posedge clk_fast or posedge rst) begin
         if (rst) begin
            filt_d <= 1'b0;
            pulse  <= 1'b0;
         end else begin
            filt_d <= filt;
            pulse  <= pulse_nxt;
         end
      end

      // A clear that coincides with a counted pulse keeps that pulse as the first event.
      always_ff @(posedge clk_fast or posedge rst) begin
         if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
         end else if (bus.cnt_clr[i]) begin
            cnt <= (pulse && edge_mode) ? CNT_W'(1) : '0;
            ovf <= 1'b0;
         end else if (pulse && edge_mode) begin
            if (cnt == CNT_MAX) ovf <= 1'b1;
            else                cnt <= cnt + CNT_W'(1);
         end
      end

      assign bus.level_out[i]              = filt;
      assign bus.pulse_out[i]              = pulse;
      assign bus.evt_cnt[i*CNT_W +: CNT_W] = cnt;
      assign bus.cnt_ovf[i]                = ovf;
   end
endmodule

// File: tb/tb_slow2fast_sync_bank.sv
// Directed bench for slow2fast_sync_bank: default-parameter instance plus a CNT_W=2
// instance for saturation; edge numbers count posedges after an input change.
module tb_slow2fast_sync_bank;
   logic clk_fast = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk_fast = ~clk_fast;

   slow2fast_sync_bank_if #(.CH(4), .CNT_W(8)) bus ();
   slow2fast_sync_bank_if #(.CH(4), .CNT_W(2)) bus_s ();

   slow2fast_sync_bank #(.CH(4), .STAGES(3), .FILT_LEN(2), .CNT_W(8)) dut (
      .clk_fast (clk_fast),
      .rst      (rst),
      .bus      (bus)
   );

   slow2fast_sync_bank #(.CH(4), .STAGES(3), .FILT_LEN(2), .CNT_W(2)) dut_s (
      .clk_fast (clk_fast),
      .rst      (rst),
      .bus      (bus_s)
   );

   task automatic step(input int n);
      repeat (n) @(negedge clk_fast);
   endtask

   function automatic logic [7:0] cnt8(input int ch);
      return bus.evt_cnt[ch*8 +: 8];
   endfunction

   function automatic logic [1:0] cnt2(input int ch);
      return bus_s.evt_cnt[ch*2 +: 2];
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      bus.data_in = '0;   bus.mode = '0;   bus.cnt_clr = '0;
      bus_s.data_in = '0; bus_s.mode = '0; bus_s.cnt_clr = '0;
      step(3);
      total++; if (bus.level_out !== 4'h0) begin bad++; $display("FAIL reset_level got %h want 0", bus.level_out); end
      total++; if (bus.pulse_out !== 4'h0) begin bad++; $display("FAIL reset_pulse got %h want 0", bus.pulse_out); end
      total++; if (bus.evt_cnt !== 32'h0) begin bad++; $display("FAIL reset_cnt got %h want 0", bus.evt_cnt); end
      total++; if (bus.cnt_ovf !== 4'h0) begin bad++; $display("FAIL reset_ovf got %h want 0", bus.cnt_ovf); end
      total++; if (bus_s.evt_cnt !== 8'h0) begin bad++; $display("FAIL reset_cnt_s got %h want 0", bus_s.evt_cnt); end
      total++; if (bus_s.cnt_ovf !== 4'h0) begin bad++; $display("FAIL reset_ovf_s got %h want 0", bus_s.cnt_ovf); end
      rst = 1'b0;
      step(3);
      total++; if (bus.level_out !== 4'h0) begin bad++; $display("FAIL post_reset_level got %h want 0", bus.level_out); end
      total++; if (bus.pulse_out !== 4'h0) begin bad++; $display("FAIL post_reset_pulse got %h want 0", bus.pulse_out); end
   endtask

   task automatic test_rise();
      logic [3:0]  exp_lvl;
      logic [3:0]  exp_pls;
      logic [31:0] exp_cnt;
      bus.mode[1:0]  = 2'b01;
      bus.data_in[0] = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         step(1);
         exp_lvl = (j >= 5) ? 4'h1 : 4'h0;
         exp_pls = (j == 6) ? 4'h1 : 4'h0;
         exp_cnt = (j >= 7) ? 32'h1 : 32'h0;
         total++; if (bus.level_out !== exp_lvl) begin bad++; $display("FAIL rise_level edge %0d got %h want %h", j, bus.level_out, exp_lvl); end
         total++; if (bus.pulse_out !== exp_pls) begin bad++; $display("FAIL rise_pulse edge %0d got %h want %h", j, bus.pulse_out, exp_pls); end
         total++; if (bus.evt_cnt !== exp_cnt) begin bad++; $display("FAIL rise_cnt edge %0d got %h want %h", j, bus.evt_cnt, exp_cnt); end
      end
      bus.data_in[0] = 1'b0;
      step(8);
      total++; if (bus.level_out[0] !== 1'b0) begin bad++; $display("FAIL rise_fall_level got %b want 0", bus.level_out[0]); end
      total++; if (cnt8(0) !== 8'd1) begin bad++; $display("FAIL rise_fall_cnt got %0d want 1", cnt8(0)); end
   endtask

   task automatic test_glitch();
      int n_lvl;
      int n_pls;
      bus.mode[3:2]  = 2'b11;
      bus.data_in[1] = 1'b1;
      step(1);
      bus.data_in[1] = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         step(1);
         total++; if (bus.level_out[1] !== 1'b0) begin bad++; $display("FAIL glitch_level edge %0d got %b want 0", j, bus.level_out[1]); end
         total++; if (bus.pulse_out[1] !== 1'b0) begin bad++; $display("FAIL glitch_pulse edge %0d got %b want 0", j, bus.pulse_out[1]); end
      end
      total++; if (cnt8(1) !== 8'd0) begin bad++; $display("FAIL glitch_cnt got %0d want 0", cnt8(1)); end
      n_lvl = 0;
      n_pls = 0;
      bus.data_in[1] = 1'b1;
      for (int j = 1; j <= 18; j++) begin
         step(1);
         if (j == 4) bus.data_in[1] = 1'b0;
         if (bus.level_out[1] === 1'b1) n_lvl++;
         if (bus.pulse_out[1] === 1'b1) n_pls++;
      end
      total++; if (n_lvl != 4) begin bad++; $display("FAIL hold4_level_cycles got %0d want 4", n_lvl); end
      total++; if (n_pls != 2) begin bad++; $display("FAIL hold4_pulses got %0d want 2", n_pls); end
      total++; if (cnt8(1) !== 8'd2) begin bad++; $display("FAIL hold4_cnt got %0d want 2", cnt8(1)); end
   endtask

   task automatic test_mode_sweep();
      int exp_n[4]     = '{10, 1, 1, 2};
      int exp_first[4] = '{6, 6, 16, 6};
      int exp_c[4]     = '{0, 1, 1, 2};
      int n_pls;
      int first;
      for (int m = 0; m < 4; m++) begin
         bus.mode[5:4]  = 2'(m);
         bus.cnt_clr[2] = 1'b1;
         step(1);
         bus.cnt_clr[2] = 1'b0;
         bus.data_in[2] = 1'b1;
         n_pls = 0;
         first = 0;
         for (int j = 1; j <= 22; j++) begin
            step(1);
            if (j == 10) bus.data_in[2] = 1'b0;
            if (bus.pulse_out[2] === 1'b1) begin
               n_pls++;
               if (first == 0) first = j;
            end
         end
         total++; if (n_pls != exp_n[m]) begin bad++; $display("FAIL sweep_pulses mode %0d got %0d want %0d", m, n_pls, exp_n[m]); end
         total++; if (first != exp_first[m]) begin bad++; $display("FAIL sweep_first mode %0d got %0d want %0d", m, first, exp_first[m]); end
         total++; if (cnt8(2) !== 8'(exp_c[m])) begin bad++; $display("FAIL sweep_cnt mode %0d got %0d want %0d", m, cnt8(2), exp_c[m]); end
      end
   endtask

   task automatic test_saturate();
      bus_s.mode[1:0] = 2'b01;
      for (int k = 1; k <= 5; k++) begin
         bus_s.data_in[0] = 1'b1;
         step(6);
         bus_s.data_in[0] = 1'b0;
         step(6);
         total++; if (cnt2(0) !== 2'((k < 3) ? k : 3)) begin bad++; $display("FAIL sat_cnt edge#%0d got %0d want %0d", k, cnt2(0), (k < 3) ? k : 3); end
         total++; if (bus_s.cnt_ovf[0] !== (k >= 4)) begin bad++; $display("FAIL sat_ovf edge#%0d got %b want %b", k, bus_s.cnt_ovf[0], (k >= 4)); end
      end
      bus_s.data_in[0] = 1'b1;
      step(6);
      total++; if (bus_s.pulse_out[0] !== 1'b1) begin bad++; $display("FAIL clr_pulse_present got %b want 1", bus_s.pulse_out[0]); end
      bus_s.cnt_clr[0] = 1'b1;
      step(1);
      bus_s.cnt_clr[0] = 1'b0;
      total++; if (cnt2(0) !== 2'd1) begin bad++; $display("FAIL clr_coincident_cnt got %0d want 1", cnt2(0)); end
      total++; if (bus_s.cnt_ovf[0] !== 1'b0) begin bad++; $display("FAIL clr_coincident_ovf got %b want 0", bus_s.cnt_ovf[0]); end
      bus_s.data_in[0] = 1'b0;
      step(8);
      total++; if (cnt2(0) !== 2'd1) begin bad++; $display("FAIL clr_after_fall_cnt got %0d want 1", cnt2(0)); end
   endtask

   task automatic test_reset_held_high();
      bus.mode[7:6]  = 2'b01;
      rst            = 1'b1;
      bus.data_in[3] = 1'b1;
      step(3);
      rst = 1'b0;
      for (int j = 1; j <= 9; j++) begin
         step(1);
         total++; if (bus.pulse_out[3] !== (j == 6)) begin bad++; $display("FAIL held_pulse edge %0d got %b want %b", j, bus.pulse_out[3], (j == 6)); end
         total++; if (bus.level_out[3] !== (j >= 5)) begin bad++; $display("FAIL held_level edge %0d got %b want %b", j, bus.level_out[3], (j >= 5)); end
      end
      total++; if (cnt8(3) !== 8'd1) begin bad++; $display("FAIL held_cnt got %0d want 1", cnt8(3)); end
      bus.data_in[3] = 1'b0;
      step(8);
   endtask

   task automatic test_reset_midflight();
      bus.mode[1:0]  = 2'b11;
      bus.data_in[0] = 1'b1;
      step(1);
      rst = 1'b1;
      step(1);
      total++; if (bus.level_out !== 4'h0) begin bad++; $display("FAIL mid_rst_level got %h want 0", bus.level_out); end
      total++; if (bus.evt_cnt !== 32'h0) begin bad++; $display("FAIL mid_rst_cnt got %h want 0", bus.evt_cnt); end
      bus.data_in[0] = 1'b0;
      step(1);
      rst = 1'b0;
      for (int j = 1; j <= 12; j++) begin
         step(1);
         total++; if (bus.level_out !== 4'h0) begin bad++; $display("FAIL mid_level edge %0d got %h want 0", j, bus.level_out); end
         total++; if (bus.pulse_out !== 4'h0) begin bad++; $display("FAIL mid_pulse edge %0d got %h want 0", j, bus.pulse_out); end
         total++; if (bus.evt_cnt !== 32'h0) begin bad++; $display("FAIL mid_cnt edge %0d got %h want 0", j, bus.evt_cnt); end
         total++; if (bus.cnt_ovf !== 4'h0) begin bad++; $display("FAIL mid_ovf edge %0d got %h want 0", j, bus.cnt_ovf); end
      end
   endtask

   initial begin
      test_reset();
      test_rise();
      test_glitch();
      test_mode_sweep();
      test_saturate();
      test_reset_held_high();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
